// File: rtl/address_offset_adder.sv
// Translates raw operand addresses that fall in the shared-code window by adding a
// per-thread default offset (from an external table, 3-cycle read) and a programmable offset.
module address_offset_adder #(
   parameter int ADDR_WIDTH   = 10,
   parameter int THREAD_WIDTH = 3,
   parameter int THREAD_COUNT = 8,
   parameter int SHARED_BASE  = 0,
   parameter int SHARED_SIZE  = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic [THREAD_WIDTH-1:0] in_thread,
   input  logic [ADDR_WIDTH-1:0]   in_addr,
   input  logic                    in_post_inc,
   output logic [THREAD_WIDTH-1:0] default_read_thread,
   input  logic [ADDR_WIDTH-1:0]   default_offset,
   input  logic                    cfg_wren,
   input  logic [THREAD_WIDTH-1:0] cfg_thread,
   input  logic [ADDR_WIDTH-1:0]   cfg_data,
   output logic                    out_valid,
   output logic [THREAD_WIDTH-1:0] out_thread,
   output logic [ADDR_WIDTH-1:0]   out_addr,
   output logic                    out_translated
);

   localparam logic [ADDR_WIDTH:0]   WIN_LO   = (ADDR_WIDTH+1)'(SHARED_BASE);
   localparam logic [ADDR_WIDTH:0]   WIN_SIZE = (ADDR_WIDTH+1)'(SHARED_SIZE);
   localparam logic [THREAD_WIDTH:0] T_COUNT  = (THREAD_WIDTH+1)'(THREAD_COUNT);

   logic                    s1_valid_q, s2_valid_q, s3_valid_q;
   logic [THREAD_WIDTH-1:0] s1_thread_q, s2_thread_q, s3_thread_q;
   logic [ADDR_WIDTH-1:0]   s1_addr_q, s2_addr_q, s3_addr_q;
   logic                    s1_inc_q, s2_inc_q, s3_inc_q;

   logic [ADDR_WIDTH-1:0]   prog_q [THREAD_COUNT];

   logic                    out_valid_q, out_valid_d;
   logic [THREAD_WIDTH-1:0] out_thread_q, out_thread_d;
   logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
   logic                    out_translated_q, out_translated_d;

   logic [ADDR_WIDTH+1:0]   rel_addr;
   logic                    in_window;
   logic                    thread_ok;
   logic                    translate;
   logic                    bump;
   logic [ADDR_WIDTH-1:0]   prog_sel;
   logic [ADDR_WIDTH-1:0]   sum_addr;

   // The table lookup is issued for every cycle's thread, valid or not.
   assign default_read_thread = in_thread;

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= in_valid;
         s2_valid_q <= s1_valid_q;
         s3_valid_q <= s2_valid_q;
      end
      s1_thread_q <= in_thread;
      s2_thread_q <= s1_thread_q;
      s3_thread_q <= s2_thread_q;
      s1_addr_q   <= in_addr;
      s2_addr_q   <= s1_addr_q;
      s3_addr_q   <= s2_addr_q;
      s1_inc_q    <= in_post_inc;
      s2_inc_q    <= s1_inc_q;
      s3_inc_q    <= s2_inc_q;
   end

   // Window test done as an offset from the base so the top edge never wraps.
   always_comb begin
      rel_addr  = {2'b00, s3_addr_q} - {1'b0, WIN_LO};
      in_window = ~rel_addr[ADDR_WIDTH+1] && (rel_addr[ADDR_WIDTH:0] < WIN_SIZE);
      thread_ok = ({1'b0, s3_thread_q} < T_COUNT);
      prog_sel  = '0;
      for (int i = 0; i < THREAD_COUNT; i++) begin
         if (s3_thread_q == THREAD_WIDTH'(i)) prog_sel = prog_q[i];
      end
      translate = s3_valid_q && in_window && thread_ok;
      bump      = translate && s3_inc_q;
      sum_addr  = s3_addr_q + default_offset + prog_sel;
   end

   always_comb begin
      out_valid_d      = 1'b0;
      out_thread_d     = out_thread_q;
      out_addr_d       = out_addr_q;
      out_translated_d = out_translated_q;
      if (s3_valid_q) begin
         out_valid_d      = 1'b1;
         out_thread_d     = s3_thread_q;
         out_addr_d       = translate ? sum_addr : s3_addr_q;
         out_translated_d = translate;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_q      <= 1'b0;
         out_thread_q     <= '0;
         out_addr_q       <= '0;
         out_translated_q <= 1'b0;
      end else begin
         out_valid_q      <= out_valid_d;
         out_thread_q     <= out_thread_d;
         out_addr_q       <= out_addr_d;
         out_translated_q <= out_translated_d;
      end
   end

   // A config write to the same entry overrides a simultaneous post-increment.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < THREAD_COUNT; i++) prog_q[i] <= '0;
      end else begin
         for (int i = 0; i < THREAD_COUNT; i++) begin
            if (cfg_wren && (cfg_thread == THREAD_WIDTH'(i)))
               prog_q[i] <= cfg_data;
            else if (bump && (s3_thread_q == THREAD_WIDTH'(i)))
               prog_q[i] <= prog_q[i] + 1'b1;
         end
      end
   end

   assign out_valid      = out_valid_q;
   assign out_thread     = out_thread_q;
   assign out_addr       = out_addr_q;
   assign out_translated = out_translated_q;

endmodule

// File: tb/tb_address_offset_adder.sv
// Bench for address_offset_adder: a default-window instance and a wide-window,
// six-thread instance share stimulus; each has its own model and expected queue.
module tb_address_offset_adder;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [2:0] in_thread = '0;
   logic [9:0] in_addr = '0;
   logic       in_post_inc = 1'b0;
   logic       cfg_wren = 1'b0;
   logic [2:0] cfg_thread = '0;
   logic [9:0] cfg_data = '0;

   logic [2:0] rd_thr [2];
   logic [9:0] def_off [2];
   logic       ov [2];
   logic [2:0] othr [2];
   logic [9:0] oaddr [2];
   logic       otr [2];

   logic [9:0] def_tab [8] = '{10'd0, 10'd0, 10'd100, 10'd2, 10'd5, 10'd0, 10'd0, 10'd0};
   logic [2:0] p0 [2] = '{3'd0, 3'd0};
   logic [2:0] p1 [2] = '{3'd0, 3'd0};
   logic [2:0] p2 [2] = '{3'd0, 3'd0};

   logic [9:0]  prog_m [2][8];
   logic [45:0] exp_q0 [$];
   logic [45:0] exp_q1 [$];
   logic [13:0] last [2] = '{14'd0, 14'd0};

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   address_offset_adder dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_thread(in_thread),
      .in_addr(in_addr), .in_post_inc(in_post_inc), .default_read_thread(rd_thr[0]),
      .default_offset(def_off[0]), .cfg_wren(cfg_wren), .cfg_thread(cfg_thread),
      .cfg_data(cfg_data), .out_valid(ov[0]), .out_thread(othr[0]),
      .out_addr(oaddr[0]), .out_translated(otr[0])
   );

   address_offset_adder #(.THREAD_COUNT(6), .SHARED_SIZE(1024)) dut_w (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_thread(in_thread),
      .in_addr(in_addr), .in_post_inc(in_post_inc), .default_read_thread(rd_thr[1]),
      .default_offset(def_off[1]), .cfg_wren(cfg_wren), .cfg_thread(cfg_thread),
      .cfg_data(cfg_data), .out_valid(ov[1]), .out_thread(othr[1]),
      .out_addr(oaddr[1]), .out_translated(otr[1])
   );

   // clock / reset block and the 3-cycle default-offset table
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(posedge clock) begin
      for (int d = 0; d < 2; d++) begin
         p0[d] <= rd_thr[d];
         p1[d] <= p0[d];
         p2[d] <= p1[d];
      end
   end
   assign def_off[0] = def_tab[p2[0]];
   assign def_off[1] = def_tab[p2[1]];

   task automatic clear_model();
      for (int d = 0; d < 2; d++)
         for (int t = 0; t < 8; t++) prog_m[d][t] = '0;
      exp_q0.delete();
      exp_q1.delete();
   endtask

   task automatic push(input int d, input logic [2:0] th, input logic [9:0] a, input logic inc);
      logic win, ok, tr;
      logic [9:0] ea;
      win = (d == 0) ? (a < 10'd16) : 1'b1;
      ok  = (d == 0) ? 1'b1 : (th < 3'd6);
      tr  = win && ok;
      ea  = tr ? (a + def_tab[th] + prog_m[d][th]) : a;
      if (tr && inc) prog_m[d][th] = prog_m[d][th] + 10'd1;
      if (d == 0) exp_q0.push_back({32'(cyc + 4), th, tr, ea});
      else        exp_q1.push_back({32'(cyc + 4), th, tr, ea});
   endtask

   task automatic drive(input logic [2:0] th, input logic [9:0] a, input logic inc);
      @(negedge clock);
      cfg_wren = 1'b0;
      in_valid = 1'b1;
      in_thread = th;
      in_addr = a;
      in_post_inc = inc;
      push(0, th, a, inc);
      push(1, th, a, inc);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rd_thr[d] !== th) begin
            errors++;
            $display("FAIL read_thread dut%0d: got %0d want %0d", d, rd_thr[d], th);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         in_valid = 1'b0;
         in_post_inc = 1'b0;
         cfg_wren = 1'b0;
         in_thread = 3'($urandom_range(0, 7));
         in_addr = 10'($urandom_range(0, 1023));
      end
   endtask

   // scoreboard: pop on every out_valid, otherwise outputs must hold
   always @(posedge clock) begin
      logic [45:0] e;
      logic        empty;
      #1;
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            last[d] = '0;
         end else if (ov[d]) begin
            empty = (d == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
            checks++;
            if (empty) begin
               errors++;
               $display("FAIL unexpected_out dut%0d: out_valid=1 addr=%0d with nothing expected", d, oaddr[d]);
            end else begin
               e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
               if ({32'(cyc), othr[d], otr[d], oaddr[d]} !== e) begin
                  errors++;
                  $display("FAIL out dut%0d: got cyc=%0d thr=%0d tr=%0d addr=%0d want cyc=%0d thr=%0d tr=%0d addr=%0d",
                           d, cyc, othr[d], otr[d], oaddr[d], e[45:14], e[13:11], e[10], e[9:0]);
               end
               last[d] = e[13:0];
            end
         end else begin
            checks++;
            if ({othr[d], otr[d], oaddr[d]} !== last[d]) begin
               errors++;
               $display("FAIL hold dut%0d: got thr=%0d tr=%0d addr=%0d want %0d/%0d/%0d", d,
                        othr[d], otr[d], oaddr[d], last[d][13:11], last[d][10], last[d][9:0]);
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      clear_model();
      repeat (3) @(negedge clock);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({ov[d], othr[d], otr[d], oaddr[d]} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state dut%0d: got v=%0d thr=%0d tr=%0d addr=%0d want all 0",
                     d, ov[d], othr[d], otr[d], oaddr[d]);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      drive(3'd2, 10'd5, 1'b0);
      idle(2);
   endtask

   task automatic test_window_edge();
      drive(3'd2, 10'd16, 1'b1);
      drive(3'd2, 10'd5, 1'b0);
      idle(2);
   endtask

   task automatic test_post_inc();
      for (int k = 0; k < 3; k++) drive(3'd1, 10'd3, 1'b1);
      idle(2);
   endtask

   task automatic test_cfg_collision();
      drive(3'd1, 10'd10, 1'b1);
      prog_m[0][1] = 10'd7;
      prog_m[1][1] = 10'd7;
      drive(3'd1, 10'd11, 1'b0);
      idle(1);
      @(negedge clock);
      in_valid = 1'b0;
      cfg_wren = 1'b1;
      cfg_thread = 3'd1;
      cfg_data = 10'd7;
      idle(4);
   endtask

   task automatic test_wrap();
      drive(3'd3, 10'd1023, 1'b0);
      idle(4);
   endtask

   task automatic test_cfg_range();
      @(negedge clock);
      in_valid = 1'b0;
      cfg_wren = 1'b1;
      cfg_thread = 3'd7;
      cfg_data = 10'd9;
      prog_m[0][7] = 10'd9;
      drive(3'd7, 10'd2, 1'b0);
      drive(3'd7, 10'd3, 1'b1);
      drive(3'd7, 10'd4, 1'b0);
      idle(4);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 30; k++)
         drive(3'($urandom_range(0, 7)), 10'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      idle(6);
   endtask

   task automatic test_reset_inflight();
      idle(2);
      for (int k = 0; k < 3; k++) drive(3'd4, 10'd1, 1'b1);
      @(negedge clock);
      in_valid = 1'b0;
      reset = 1'b1;
      clear_model();
      @(negedge clock);
      reset = 1'b0;
      repeat (6) begin
         @(negedge clock);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({ov[d], othr[d], otr[d], oaddr[d]} !== 15'd0) begin
               errors++;
               $display("FAIL reset_flush dut%0d: got v=%0d thr=%0d tr=%0d addr=%0d want all 0",
                        d, ov[d], othr[d], otr[d], oaddr[d]);
            end
         end
      end
      for (int t = 0; t < 8; t++) drive(3'(t), 10'd4, 1'b0);
      idle(2);
   endtask

   initial begin
      int waited;
      clear_model();
      test_reset();
      test_basic();
      test_window_edge();
      test_post_inc();
      test_cfg_collision();
      test_wrap();
      test_cfg_range();
      test_back_to_back();
      test_reset_inflight();
      waited = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0) && waited < 50) begin
         @(posedge clock);
         waited++;
      end
      checks++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d/%0d results never arrived, want 0/0", exp_q0.size(), exp_q1.size());
      end
      repeat (2) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/address_offset_adder.md
ADDRESS_OFFSET_ADDER -- requirements
Module: address_offset_adder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, width of operand addresses and offsets.
REQ-002 SHALL have parameter THREAD_WIDTH, default 3, width of thread numbers.
REQ-003 SHALL have parameter THREAD_COUNT, default 8, number of threads and of programmed-offset entries (<= 2**THREAD_WIDTH).
REQ-004 SHALL have parameter SHARED_BASE, default 0, first address of the shared-code window.
REQ-005 SHALL have parameter SHARED_SIZE, default 16, number of addresses in the shared window.
REQ-006 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port in_valid  input  1  raw address present this cycle.
REQ-009 SHALL have port in_thread  input  THREAD_WIDTH  thread owning the raw address.
REQ-010 SHALL have port in_addr  input  ADDR_WIDTH  raw operand address.
REQ-011 SHALL have port in_post_inc  input  1  post-increment request for this access.
REQ-012 SHALL have port default_read_thread  output  THREAD_WIDTH  thread index to the default-offset table; combinationally equal to in_thread.
REQ-013 SHALL have port default_offset  input  ADDR_WIDTH  per-thread default offset, valid exactly 3 cycles after default_read_thread is driven.
REQ-014 SHALL have port cfg_wren  input  1  programmed-offset write enable.
REQ-015 SHALL have port cfg_thread  input  THREAD_WIDTH  programmed-offset write index.
REQ-016 SHALL have port cfg_data  input  ADDR_WIDTH  programmed-offset write value.
REQ-017 SHALL have port out_valid  output  1  translated address valid.
REQ-018 SHALL have port out_thread  output  THREAD_WIDTH  thread of the translated address.
REQ-019 SHALL have port out_addr  output  ADDR_WIDTH  translated address.
REQ-020 SHALL have port out_translated  output  1  address was inside the shared window.

Function
REQ-021 SHALL carry in_valid, in_thread, in_addr and in_post_inc through three pipeline registers (S1..S3), aligning S3 with default_offset.
REQ-022 SHALL, at S3, flag in_window when SHARED_BASE <= addr < SHARED_BASE+SHARED_SIZE, compared unsigned at ADDR_WIDTH+1 bits, so no wrap-around at the window top.
REQ-023 SHALL register out_addr = addr + default_offset + prog_offset[thread], truncated mod 2**ADDR_WIDTH, when S3 is valid and in_window.
REQ-024 SHALL register out_addr = addr unchanged, with out_translated=0, when S3 is valid and not in_window.
REQ-025 SHALL give a total latency of 4 cycles from in_valid to out_valid, with one result per cycle and no stalls.
REQ-026 SHALL hold out_valid=0 and the previous out_addr/out_thread/out_translated values in cycles after an invalid S3.
REQ-027 SHALL, when S3 is valid, in_window and post_inc=1, update prog_offset[thread] to prog_offset[thread]+1 mod 2**ADDR_WIDTH at the same edge out_addr registers.
REQ-028 SHALL make a post-increment visible to the next S3 access of the same thread, including in the immediately following cycle (pre-increment value used by the incrementing access).
REQ-029 SHALL write prog_offset[cfg_thread] = cfg_data on cfg_wren; when it collides with a post-increment to the same entry, the cfg write wins.
REQ-030 SHALL ignore cfg writes and accesses whose thread is >= THREAD_COUNT (no state change; the access passes through untranslated).
REQ-031 SHALL not gate default_read_thread with in_valid.

Reset
REQ-032 SHALL, on reset, clear S1..S3 valids, out_valid, out_translated, out_addr and out_thread to 0, and every prog_offset entry to 0.
REQ-033 SHALL discard in-flight accesses on reset mid-operation; no post-increment or cfg write occurs in a reset cycle.
REQ-034 SHALL give first valid output exactly 4 cycles after the first in_valid following reset release.

Verification
REQ-035 SHALL verify: thread 2, addr 5, default_offset 100, prog 0 -> out_addr 105, out_translated 1, 4 cycles later.
REQ-036 SHALL verify: addr 16 with window 0..15 -> out_addr 16, out_translated 0, prog_offset unchanged despite post_inc.
REQ-037 SHALL verify: thread 1, addr 3, post_inc on 3 consecutive cycles, default 0 -> out_addr 3, 4, 5.
REQ-038 SHALL verify: cfg_wren thread 1 data 7 in the same cycle as a thread-1 post-increment -> next access sees prog 7.
REQ-039 SHALL verify: addr 1023, default_offset 2, ADDR_WIDTH 10 -> out_addr 1, with the window widened to cover 1023.
REQ-040 SHALL verify: reset asserted with 3 accesses in flight -> no out_valid afterward; prog_offset all 0.
